// File: rtl/spi_status_unit_if.sv
// Host/shifter-facing strobe and status bundle of spi_status_unit.
// master drives the strobes, slave is the status unit itself.
interface spi_status_unit_if #(
   parameter int unsigned LW = 4
);
   logic          TX_PUSH;
   logic          TX_POP;
   logic          TX_FLUSH;
   logic          RX_PUSH;
   logic          RX_POP;
   logic          RX_FLUSH;
   logic          W1C_STB;
   logic [7:0]    W1C_DATA;
   logic          IE_WR;
   logic [7:0]    IE_DATA;
   logic [7:0]    STATUS;
   logic [LW-1:0] TX_LEVEL;
   logic [LW-1:0] RX_LEVEL;
   logic [7:0]    IE;
   logic          IRQ;

   modport master (
      output TX_PUSH, TX_POP, TX_FLUSH, RX_PUSH, RX_POP, RX_FLUSH,
      output W1C_STB, W1C_DATA, IE_WR, IE_DATA,
      input  STATUS, TX_LEVEL, RX_LEVEL, IE, IRQ
   );

   modport slave (
      input  TX_PUSH, TX_POP, TX_FLUSH, RX_PUSH, RX_POP, RX_FLUSH,
      input  W1C_STB, W1C_DATA, IE_WR, IE_DATA,
      output STATUS, TX_LEVEL, RX_LEVEL, IE, IRQ
   );
endinterface

// File: rtl/spi_status_unit.sv
// SPI buffer status/interrupt unit: saturating occupancy counters, level flags,
// sticky overflow/overrun bits with write-1-to-clear, and a maskable registered IRQ.
module spi_status_unit #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TX_WM = 2,
   parameter int unsigned RX_WM = 6,
   parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
   input logic              S_CLK,
   input logic              CLR_N,
   spi_status_unit_if.slave bus
);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] TX_WM_L = LW'(TX_WM);
   localparam logic [LW-1:0] RX_WM_L = LW'(RX_WM);

   logic [LW-1:0] tx_level;
   logic [LW-1:0] rx_level;
   logic          tx_ovf;
   logic          rx_ovr;
   logic [7:0]    ie;
   logic          irq;

   logic [LW-1:0] tx_level_nxt_c;
   logic [LW-1:0] rx_level_nxt_c;
   logic          tx_ovf_set_c;
   logic          rx_ovr_set_c;
   logic [7:0]    status_c;

   // Saturating level update; flush wins, push+pop at empty counts as push only.
   function automatic logic [LW-1:0] lvl_next(input logic [LW-1:0] lvl,
                                              input logic push,
                                              input logic pop,
                                              input logic flush);
      logic [LW-1:0] res;
      res = lvl;
      if (flush) begin
         res = '0;
      end else if (push && pop) begin
         if (lvl == '0) res = LW'(1);
      end else if (push) begin
         if (lvl != DEPTH_L) res = lvl + LW'(1);
      end else if (pop) begin
         if (lvl != '0) res = lvl - LW'(1);
      end
      return res;
   endfunction

   always_comb begin
      tx_level_nxt_c = lvl_next(tx_level, bus.TX_PUSH, bus.TX_POP, bus.TX_FLUSH);
      rx_level_nxt_c = lvl_next(rx_level, bus.RX_PUSH, bus.RX_POP, bus.RX_FLUSH);
      tx_ovf_set_c   = bus.TX_PUSH && !bus.TX_POP && !bus.TX_FLUSH && (tx_level == DEPTH_L);
      rx_ovr_set_c   = bus.RX_PUSH && !bus.RX_POP && !bus.RX_FLUSH && (rx_level == DEPTH_L);
   end

   always_comb begin
      status_c    = '0;
      status_c[0] = (tx_level == '0);
      status_c[1] = (tx_level == DEPTH_L);
      status_c[2] = (tx_level <= TX_WM_L);
      status_c[3] = tx_ovf;
      status_c[4] = (rx_level != '0);
      status_c[5] = (rx_level == DEPTH_L);
      status_c[6] = (rx_level >= RX_WM_L);
      status_c[7] = rx_ovr;
   end

   // Sticky bits: a same-cycle set overrides the clear mask.
   always_ff @(posedge S_CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         tx_level <= '0;
         rx_level <= '0;
         tx_ovf   <= 1'b0;
         rx_ovr   <= 1'b0;
         ie       <= 8'h00;
         irq      <= 1'b0;
      end else begin
         tx_level <= tx_level_nxt_c;
         rx_level <= rx_level_nxt_c;
         tx_ovf   <= tx_ovf_set_c | (tx_ovf & ~(bus.W1C_STB & bus.W1C_DATA[3]));
         rx_ovr   <= rx_ovr_set_c | (rx_ovr & ~(bus.W1C_STB & bus.W1C_DATA[7]));
         if (bus.IE_WR) ie <= bus.IE_DATA;
         irq      <= |(status_c & ie);
      end
   end

   assign bus.STATUS   = status_c;
   assign bus.TX_LEVEL = tx_level;
   assign bus.RX_LEVEL = rx_level;
   assign bus.IE       = ie;
   assign bus.IRQ      = irq;
endmodule

// File: tb/tb_spi_status_unit.sv
// Scoreboard bench for spi_status_unit: driver pushes model expectations,
// an independent monitor pops and compares them against the outputs.
module tb_spi_status_unit;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TX_WM = 2;
   localparam int unsigned RX_WM = 6;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic S_CLK = 1'b0;
   logic CLR_N = 1'b0;
   always #5 S_CLK = ~S_CLK;

   spi_status_unit_if #(.LW(LW)) bus ();

   spi_status_unit #(.DEPTH(DEPTH), .TX_WM(TX_WM), .RX_WM(RX_WM), .LW(LW)) dut (
      .S_CLK (S_CLK),
      .CLR_N (CLR_N),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] status;
      int         tx;
      int         rx;
      logic [7:0] ie;
      logic       irq;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   event chk_ev;

   // Reference model state
   int         m_tx, m_rx;
   bit         m_ovf, m_ovr, m_irq;
   logic [7:0] m_ie;

   function automatic logic [7:0] m_status();
      logic [7:0] s;
      s[0] = (m_tx == 0);
      s[1] = (m_tx == DEPTH);
      s[2] = (m_tx <= TX_WM);
      s[3] = m_ovf;
      s[4] = (m_rx != 0);
      s[5] = (m_rx == DEPTH);
      s[6] = (m_rx >= RX_WM);
      s[7] = m_ovr;
      return s;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.status = m_status();
      e.tx = m_tx; e.rx = m_rx; e.ie = m_ie; e.irq = m_irq;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_tx = 0; m_rx = 0; m_ovf = 0; m_ovr = 0; m_irq = 0; m_ie = 8'h00;
   endtask

   // Occupancy rule from the buffer semantics: returns new level, flags a dropped push.
   task automatic model_buf(inout int lvl, inout bit sticky, input bit push, input bit pop,
                            input bit flush);
      if (flush) lvl = 0;
      else if (push && pop) lvl = (lvl == 0) ? 1 : lvl;
      else if (push) begin
         if (lvl < DEPTH) lvl++;
         else sticky = 1;
      end else if (pop && lvl > 0) lvl--;
   endtask

   task automatic set_idle();
      bus.TX_PUSH = 0; bus.TX_POP = 0; bus.TX_FLUSH = 0;
      bus.RX_PUSH = 0; bus.RX_POP = 0; bus.RX_FLUSH = 0;
      bus.W1C_STB = 0; bus.W1C_DATA = 8'h00; bus.IE_WR = 0; bus.IE_DATA = 8'h00;
   endtask

   // One clock of stimulus, called at a falling edge and returning at the next one.
   task automatic cycle(input bit tp, input bit tpo, input bit tf, input bit rp, input bit rpo,
                        input bit rf, input bit w, input logic [7:0] wd, input bit iw,
                        input logic [7:0] id);
      bit ovf_set, ovr_set;
      bus.TX_PUSH = tp; bus.TX_POP = tpo; bus.TX_FLUSH = tf;
      bus.RX_PUSH = rp; bus.RX_POP = rpo; bus.RX_FLUSH = rf;
      bus.W1C_STB = w; bus.W1C_DATA = wd; bus.IE_WR = iw; bus.IE_DATA = id;
      @(posedge S_CLK);
      m_irq = |(m_status() & m_ie);
      ovf_set = 0; ovr_set = 0;
      model_buf(m_tx, ovf_set, tp, tpo, tf);
      model_buf(m_rx, ovr_set, rp, rpo, rf);
      m_ovf = ovf_set || (m_ovf && !(w && wd[3]));
      m_ovr = ovr_set || (m_ovr && !(w && wd[7]));
      if (iw) m_ie = id;
      #1;
      push_exp();
      @(negedge S_CLK);
      set_idle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0,0,0,0,0,0,0,8'h00,0,8'h00);
   endtask

   // Asynchronous reset mid-cycle; checked before any further clock edge.
   task automatic do_reset();
      #2;
      set_idle();
      CLR_N = 1'b0;
      model_reset();
      push_exp();
      #1;
      ->chk_ev;
      @(negedge S_CLK);
      CLR_N = 1'b1;
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares each expectation whenever one is pending.
   initial begin
      exp_t e;
      forever begin
         @(negedge S_CLK or chk_ev);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("status", int'(bus.STATUS), int'(e.status));
            cmp("tx_level", int'(bus.TX_LEVEL), e.tx);
            cmp("rx_level", int'(bus.RX_LEVEL), e.rx);
            cmp("ie", int'(bus.IE), int'(e.ie));
            cmp("irq", int'(bus.IRQ), int'(e.irq));
         end
      end
   end

   initial begin
      set_idle();
      model_reset();
      CLR_N = 1'b0;
      @(negedge S_CLK);
      @(negedge S_CLK);
      push_exp();
      ->chk_ev;
      #1;
      CLR_N = 1'b1;
      @(negedge S_CLK);

      // Fill TX to 3, then to full, overflow, push+pop at full
      repeat (3) cycle(1,0,0,0,0,0,0,8'h00,0,8'h00);
      repeat (5) cycle(1,0,0,0,0,0,0,8'h00,0,8'h00);
      cycle(1,0,0,0,0,0,0,8'h00,0,8'h00);
      cycle(1,1,0,0,0,0,0,8'h00,0,8'h00);
      cycle(0,0,0,0,0,0,1,8'h08,0,8'h00);

      // RX high watermark with IRQ enabled, then drop it by a pop
      cycle(0,0,0,0,0,0,0,8'h00,1,8'h40);
      repeat (6) cycle(0,0,0,1,0,0,0,8'h00,0,8'h00);
      idle(2);
      cycle(0,0,0,0,1,0,0,8'h00,0,8'h00);
      idle(2);

      // RX overrun; clear collides with another overflowing push, then clears alone
      repeat (3) cycle(0,0,0,1,0,0,0,8'h00,0,8'h00);
      cycle(0,0,0,1,0,0,1,8'h80,0,8'h00);
      cycle(0,0,0,0,0,0,1,8'h80,0,8'h00);
      cycle(0,0,0,0,0,1,0,8'h00,0,8'h00);

      // Pop and push+pop at empty, then flush with push at level 5
      cycle(0,0,1,0,0,0,0,8'h00,0,8'h00);
      cycle(0,1,0,0,0,0,0,8'h00,0,8'h00);
      cycle(1,1,0,0,0,0,0,8'h00,0,8'h00);
      repeat (4) cycle(1,0,0,0,0,0,0,8'h00,0,8'h00);
      repeat (9) cycle(0,0,0,1,0,0,0,8'h00,0,8'h00);
      cycle(1,0,1,0,0,0,0,8'h00,0,8'h00);
      cycle(0,0,0,0,0,0,1,8'h77,0,8'h00);

      // Reset mid-sequence at level 4 with IRQ asserted
      repeat (4) cycle(1,0,0,0,0,0,0,8'h00,1,8'h81);
      idle(2);
      do_reset();
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 12, 8'($urandom),
                    $urandom_range(0, 99) < 6, 8'($urandom));
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge S_CLK);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
